// File: rtl/priority_encoder_arb.sv
// Registered N-input priority arbiter with fixed / round-robin selection
// and a grant held until acknowledged.
module priority_encoder_arb #(
    parameter  int N = 8,
    localparam int W = $clog2(N + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_req,
    input  logic         i_mode,
    input  logic         i_ack,
    output logic         o_valid,
    output logic [W-1:0] o_pcode,
    output logic [N-1:0] o_grant
);

    localparam int LW = $clog2(N);

    localparam logic IDLE  = 1'b0;
    localparam logic GRANT = 1'b1;

    logic          state_q, state_d;
    logic [LW-1:0] last_q, last_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [W-1:0]  pcode_q, pcode_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [LW-1:0] win;
    logic          found;
    logic          arb;
    int            cand;

    // An acknowledge retires the held winner into the round-robin pointer
    // before this edge's arbitration looks at it.
    always_comb begin
        last_d = last_q;
        arb    = 1'b1;
        if (state_q == GRANT) begin
            arb = i_ack;
            if (i_ack) begin
                last_d = idx_q;
            end
        end
    end

    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = 0;
        if (!i_mode) begin
            for (int k = 0; k < N; k++) begin
                if (i_req[k]) begin
                    win = LW'(k);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                cand = (int'(last_d) + 2 * N - 1 - i) % N;
                if (!found && i_req[cand]) begin
                    found = 1'b1;
                    win   = LW'(cand);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pcode_d = pcode_q;
        grant_d = grant_q;
        if (arb) begin
            if (i_req == '0) begin
                state_d = IDLE;
                idx_d   = '0;
                pcode_d = '0;
                grant_d = '0;
            end else begin
                state_d = GRANT;
                idx_d   = win;
                pcode_d = W'(win) + W'(1);
                grant_d = N'(1) << win;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            last_q  <= '0;
            idx_q   <= '0;
            pcode_q <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            pcode_q <= pcode_d;
            grant_q <= grant_d;
        end
    end

    assign o_valid = (state_q == GRANT);
    assign o_pcode = pcode_q;
    assign o_grant = grant_q;

endmodule

// File: tb/tb_priority_encoder_arb.sv
// Self-checking bench for priority_encoder_arb: directed plan cases plus
// randomized traffic against a behavioural arbitration model.
module tb_priority_encoder_arb;

    localparam int N = 8;
    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         mode;
    logic         ack;
    logic         valid;
    logic [W-1:0] pcode;
    logic [N-1:0] grant;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    bit m_valid;
    int m_idx;
    int m_last;

    priority_encoder_arb #(.N(N)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_req  (req),
        .i_mode (mode),
        .i_ack  (ack),
        .o_valid(valid),
        .o_pcode(pcode),
        .o_grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input bit md,
                                input int lst);
        int start;
        if (!md) begin
            for (int k = N - 1; k >= 0; k--)
                if (r[k]) return k;
        end else begin
            start = (lst + N - 1) % N;
            for (int i = 0; i < N; i++)
                if (r[(start - i + N) % N]) return (start - i + N) % N;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [N-1:0] r, input bit md,
                              input bit a);
        bit arb_now;
        arb_now = !m_valid || a;
        if (m_valid && a) m_last = m_idx;
        if (arb_now) begin
            if (r == '0) begin
                m_valid = 1'b0;
                m_idx   = 0;
            end else begin
                m_valid = 1'b1;
                m_idx   = pick(r, md, m_last);
            end
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_last  = 0;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] ep;
        logic [31:0] eg;
        ep = m_valid ? 32'(m_idx + 1) : 32'd0;
        eg = m_valid ? (32'd1 << m_idx) : 32'd0;
        check({tag, ".valid"}, 32'(valid), 32'(m_valid));
        check({tag, ".pcode"}, 32'(pcode), ep);
        check({tag, ".grant"}, 32'(grant), eg);
    endtask

    task automatic step(input logic [N-1:0] r, input bit md, input bit a,
                        input string tag);
        @(negedge clk);
        req  = r;
        mode = md;
        ack  = a;
        @(posedge clk);
        model_edge(r, md, a);
        #1;
        check_model(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        req   = 8'hFF;
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, ".valid"}, 32'(valid), 32'd0);
        check({tag, ".pcode"}, 32'(pcode), 32'd0);
        check({tag, ".grant"}, 32'(grant), 32'd0);
        @(negedge clk);
        req   = '0;
        ack   = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r;
        rst_n = 1'b0;
        req   = 8'hFF;
        mode  = 1'b0;
        ack   = 1'b0;
        model_reset();
        #3;
        check("por.valid", 32'(valid), 32'd0);
        check("por.pcode", 32'(pcode), 32'd0);
        check("por.grant", 32'(grant), 32'd0);
        @(negedge clk);
        req   = '0;
        rst_n = 1'b1;

        // Fixed priority with hold
        step(8'b0010_0110, 1'b0, 1'b0, "fix");
        check("fix.p6", 32'(pcode), 32'd6);
        check("fix.g20", 32'(grant), 32'h20);
        for (int i = 0; i < 3; i++) begin
            step(8'h01, 1'b0, 1'b0, "hold");
            check("hold.p6", 32'(pcode), 32'd6);
        end
        step(8'h01, 1'b0, 1'b1, "ackfix");
        check("ackfix.p1", 32'(pcode), 32'd1);
        check("ackfix.g01", 32'(grant), 32'h01);

        // Fixed starvation
        for (int i = 0; i < 6; i++) begin
            step(8'h81, 1'b0, 1'b1, "starve");
            check("starve.p8", 32'(pcode), 32'd8);
            check("starve.v", 32'(valid), 32'd1);
        end

        // Reset mid-grant, then round-robin sweep from reset
        async_reset("rst1");
        for (int i = 0; i < 9; i++) begin
            step(8'hFF, 1'b1, 1'b1, "sweep");
            check("sweep.seq", 32'(pcode), 32'((i == 8) ? 8 : 8 - i));
            check("sweep.v", 32'(valid), 32'd1);
        end

        // Sparse round-robin and release
        async_reset("rst2");
        for (int i = 0; i < 4; i++) begin
            step(8'h11, 1'b1, 1'b1, "sparse");
            check("sparse.seq", 32'(pcode), 32'((i % 2 == 0) ? 5 : 1));
        end
        step(8'h00, 1'b1, 1'b1, "release");
        check("release.v", 32'(valid), 32'd0);
        check("release.p", 32'(pcode), 32'd0);

        // Ack while idle is ignored
        step(8'h00, 1'b1, 1'b1, "idleack");

        // Hold an RR grant at code 3, reset mid-grant
        step(8'h04, 1'b1, 1'b0, "rr3");
        check("rr3.p3", 32'(pcode), 32'd3);
        step(8'hFF, 1'b1, 1'b0, "rr3hold");
        check("rr3hold.p3", 32'(pcode), 32'd3);
        async_reset("rst3");
        step(8'hFF, 1'b1, 1'b0, "post");
        check("post.p8", 32'(pcode), 32'd8);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: r = '0;
                1: r = N'(1) << $urandom_range(0, N - 1);
                2: r = N'($urandom) & N'($urandom);
                default: r = N'($urandom);
            endcase
            step(r, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) < 60), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/priority_encoder_arb.md
# priority_encoder_arb

Parametrised, registered N-input priority encoder/arbiter. It is the next generation of the 4-input combinational priority encoder. It adds:
- a configurable request count;
- a runtime-selectable fixed-priority or round-robin mode;
- a held grant with an acknowledge handshake.

It sits between a bank of request sources and a single shared resource. It outputs the winner as a 1-based code (0 = none) and as a one-hot grant.

## Interface
Parameters:
- N, default 8: number of request lines; legal range N >= 2.
- W, derived as $clog2(N+1) (localparam, not overridable): code width; N=8 gives W=4.

Ports:
- i_clk  input  1  single clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, asynchronous and active-low.
- i_req  input  N  request vector; bit k is source k.
- i_mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
- i_ack  input  1  consumer acknowledge of the current grant.
- o_valid  output  1  a grant is held.
- o_pcode  output  W  winner index + 1; 0 when o_valid=0.
- o_grant  output  N  one-hot winner; all-zero when o_valid=0.

## Operation
- State machine, two states:
  - IDLE: o_valid=0.
  - GRANT: o_valid=1; o_pcode and o_grant are frozen.
- Internal pointer `last` (log2 N bits): index of the most recently acknowledged winner. Reset value is 0.
- Arbitration instant: any rising edge where one of the following holds:
  - state is IDLE;
  - state is GRANT and i_ack=1.
- At an arbitration instant, i_req and i_mode are sampled.
  - If i_req == 0: go to IDLE, drive outputs to 0.
  - Otherwise: register the winner k, set o_pcode = k+1, o_grant = 1<<k, o_valid=1; go to (or stay in) GRANT.
- Fixed mode: the winner is the highest set index in i_req, as in the 4-input encoder.
- Round-robin mode: search order starts at index (last-1) mod N and descends with wraparound. The first set bit wins.
  - After reset (last=0), the search starts at N-1, so both modes give the same result at reset.
- When a grant is acknowledged, `last` takes the acknowledged winner index on that edge. The update happens in both modes.
  - Arbitration on that edge uses the updated value of `last`.
- GRANT hold rules:
  - Changes to i_req are ignored while the grant is held. The winner dropping its request does not withdraw the grant.
  - i_mode changes take effect only at the next arbitration instant.
- i_ack while in IDLE is ignored.
- Fixed mode can starve low indices by design. The acknowledged winner is eligible again immediately.
- The async reset asserted at any time, including mid-grant, has this effect immediately (no clock needed):
  - o_valid=0, o_pcode=0, o_grant=0;
  - state = IDLE, last = 0.
- Reset deassertion is taken synchronously by the integrator. The first arbitration happens on the first rising edge after i_rst_n goes high.

## Timing
- Reset values: o_valid=0, o_pcode=0, o_grant=0, last=0, state IDLE.
- All outputs are registered. No combinational path runs from any input to any output.
- Latency: a request is sampled at edge t in IDLE, and the grant is visible after edge t. That is one cycle from request to grant.
- Back-to-back throughput: i_ack=1 at edge t with other requests pending gives a new grant after edge t. o_valid stays high and there is no idle bubble, so one grant per cycle is possible.
- A grant lasts from its arbitration edge until the edge where i_ack=1 is sampled. Minimum duration is one cycle.
- Ack and a new request arrive at the same edge: the new request is included in that arbitration.

## Test plan
- Reset: assert i_rst_n=0 with i_req=8'hFF mid-cycle. Required: o_valid=0, o_pcode=0, o_grant=0 immediately, with no clock edge.
- Fixed hold: mode=0, i_req=8'b0010_0110, i_ack=0. Required after one edge: o_pcode=6, o_grant=8'h20.
  - Then change i_req to 8'h01 for 3 cycles. Required: outputs unchanged.
  - Then pulse i_ack. Required: o_pcode=1, o_grant=8'h01.
- Fixed starvation: mode=0, i_req=8'h81 held, i_ack=1 every cycle. Required: o_pcode=8 on every cycle and o_valid continuously 1.
- Round-robin sweep: from reset, mode=1, i_req=8'hFF, i_ack=1 every cycle. Required: o_pcode sequence 8,7,6,5,4,3,2,1,8 with no bubbles.
- Round-robin sparse plus release: mode=1, i_req=8'h11, ack every cycle. Required: o_pcode 5,1,5,1.
  - Then set i_req=0 with ack. Required: o_valid=0, o_pcode=0 on the next edge.
- Reset mid-grant: RR grant with o_pcode=3 held, then assert reset. Required: outputs cleared at once.
  - After release with i_req=8'hFF, mode=1: required first o_pcode=8, since last was cleared to 0.
